// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the async FIFO read-side stream reader.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        RD_EMPTY = 2'd0,
        RD_ONE   = 2'd1,
        RD_TWO   = 2'd2
    } rd_state_t;

    localparam int RD_BUF_DEPTH = 2;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus downstream valid/ready stream, bundled for the reader.
interface fifo_stream_reader_if #(
    parameter int DSIZE = 8
);
    logic [DSIZE-1:0] rdata;
    logic             rempty;
    logic             rinc;
    logic             m_valid;
    logic [DSIZE-1:0] m_data;
    logic             m_ready;

    modport master (
        input  rdata, rempty, m_ready,
        output rinc, m_valid, m_data
    );

    modport slave (
        output rdata, rempty, m_ready,
        input  rinc, m_valid, m_data
    );
endinterface

// File: rtl/fifo_rd_sat_cnt.sv
// Saturating event counter in the read clock domain; clears only on reset.
module fifo_rd_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side consumer for async_fifo: pops FWFT words into a 2-entry skid buffer.
// Optional statistics counters are built only when FIFO_RD_STATS_EN is defined.
module fifo_stream_reader
    import fifo_rd_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int CNT_W = 16
) (
    input  logic                 rclk,
    input  logic                 rrst_n,
    fifo_stream_reader_if.master bus,
    input  logic                 en,
    input  logic                 flush,
    output logic [CNT_W-1:0]     pop_count,
    output logic [CNT_W-1:0]     stall_count
);

    rd_state_t        r_state;
    rd_state_t        w_state_nxt;
    logic             r_live;
    logic [DSIZE-1:0] r_ent     [RD_BUF_DEPTH];
    logic [DSIZE-1:0] w_ent_nxt [RD_BUF_DEPTH];
    logic             w_push;
    logic             w_pop;
    logic             w_valid;

    // rinc sees only registered occupancy, so m_ready never reaches the FIFO
    assign w_valid = (r_state != RD_EMPTY);
    assign w_push  = r_live & en & ~bus.rempty & (r_state != RD_TWO) & ~flush;
    assign w_pop   = w_valid & bus.m_ready;

    assign bus.rinc    = w_push;
    assign bus.m_valid = w_valid;
    assign bus.m_data  = r_ent[0];

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_state <= RD_EMPTY;
            r_live  <= 1'b0;
            for (int i = 0; i < RD_BUF_DEPTH; i++) begin
                r_ent[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_live  <= 1'b1;
            for (int i = 0; i < RD_BUF_DEPTH; i++) begin
                r_ent[i] <= w_ent_nxt[i];
            end
        end
    end

    // Entry 0 is the head; entry 1 only ever holds the second word in RD_TWO
    always_comb begin
        w_state_nxt = r_state;
        for (int i = 0; i < RD_BUF_DEPTH; i++) begin
            w_ent_nxt[i] = r_ent[i];
        end
        if (flush) begin
            w_state_nxt = RD_EMPTY;
        end else begin
            case (r_state)
                RD_EMPTY: begin
                    if (w_push) begin
                        w_state_nxt  = RD_ONE;
                        w_ent_nxt[0] = bus.rdata;
                    end
                end
                RD_ONE: begin
                    case ({w_push, w_pop})
                        2'b10: begin
                            w_state_nxt  = RD_TWO;
                            w_ent_nxt[1] = bus.rdata;
                        end
                        2'b01: begin
                            w_state_nxt = RD_EMPTY;
                        end
                        2'b11: begin
                            w_ent_nxt[0] = bus.rdata;
                        end
                        default: begin
                            w_state_nxt = RD_ONE;
                        end
                    endcase
                end
                RD_TWO: begin
                    if (w_pop) begin
                        w_state_nxt  = RD_ONE;
                        w_ent_nxt[0] = r_ent[1];
                    end
                end
                default: begin
                    w_state_nxt = RD_EMPTY;
                end
            endcase
        end
    end

`ifdef FIFO_RD_STATS_EN
    fifo_rd_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_pop_cnt (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .inc    (w_push),
        .count  (pop_count)
    );

    fifo_rd_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .inc    (w_valid & ~bus.m_ready),
        .count  (stall_count)
    );
`else
    assign pop_count   = '0;
    assign stall_count = '0;
`endif

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side consumer for `async_fifo`, in the `rclk` domain. Pops words from the FIFO read port (`rinc`/`rdata`/`rempty`) and presents them downstream as a registered valid/ready stream through a 2-entry skid buffer. Sustains one word per cycle with no combinational path from `m_ready` to `rinc`. Completes the read end of the FIFO protocol that the write-side stimulus and DPI checker exercise.

## Interface
Parameters:
- `DSIZE`, 8: data width; matches `async_fifo` DSIZE.
- `CNT_W`, 16: width of statistics counters.

Ports:
- `rclk`  in  1  read-domain clock; all logic on its rising edge.
- `rrst_n`  in  1  asynchronous, active-low reset.
- `rdata`  in  DSIZE  FIFO head word; first-word-fall-through, valid whenever `rempty`=0.
- `rempty`  in  1  FIFO empty flag.
- `rinc`  out  1  pop request; the FIFO pops on the `rclk` edge where `rinc`=1 and `rempty`=0.
- `en`  in  1  drain enable; 0 stops new pops but does not stop output.
- `flush`  in  1  synchronous clear of the skid buffer.
- `m_valid`  out  1  output word valid.
- `m_data`  out  DSIZE  output word.
- `m_ready`  in  1  downstream accept.
- `pop_count`  out  CNT_W  saturating count of pops (see Configuration).
- `stall_count`  out  CNT_W  saturating count of backpressure cycles (see Configuration).

## Operation
- Buffer occupancy state: `RD_EMPTY`(0), `RD_ONE`(1), `RD_TWO`(2). Head entry drives `m_data`. `m_valid` = state != `RD_EMPTY`.
- `live` register: 0 in reset; set on the first `rclk` edge after `rrst_n` deasserts.
- `rinc` = `live` & `en` & !`rempty` & (state != `RD_TWO`) & !`flush`. It depends only on registered state and FIFO/control inputs, never on `m_ready`.
- push = `rinc` (captures `rdata` into the tail entry). pop = `m_valid` & `m_ready`.
- Transitions:
  - EMPTY: push → ONE.
  - ONE: push & !pop → TWO; !push & pop → EMPTY; push & pop → ONE, with new word at head next cycle.
  - TWO: pop → ONE, with the second entry shifted to head. Push is impossible in TWO.
- `flush` = 1: state → EMPTY and `m_valid` → 0 next cycle. Any concurrent pop/push is ignored; `rinc` is forced 0, so no FIFO word is lost.
- `en` falling mid-stream: buffered words still drain to downstream.
- Words are never duplicated, dropped or reordered.

## Timing
- Reset values: `m_valid`=0, `m_data`=0, `rinc`=0, state EMPTY, `live`=0, both counters 0.
- `rinc` stays 0 during reset and on the first edge after release.
- Latency from `rempty` falling (with `en`=1, buffer not full) to `m_valid`: `rinc` asserts the same cycle; `m_valid`=1 after 1 `rclk` edge.
- Throughput: 1 word/cycle in steady state, state holding in ONE while `m_ready`=1.
- Full backpressure (`m_ready`=0): exactly 2 words are buffered, then `rinc`=0 until a pop.
- `m_data` holds stable while `m_valid`=1 and `m_ready`=0.
- Reset mid-operation: all state clears asynchronously; buffered words are discarded. FIFO contents are untouched because the FIFO reset is separate.

## Configuration
- `FIFO_RD_STATS_EN` defined:
  - `pop_count` increments on every cycle with `rinc`=1.
  - `stall_count` increments on every cycle with `m_valid`=1 and `m_ready`=0.
  - Both saturate at 2^CNT_W-1 and clear only on reset.
- `FIFO_RD_STATS_EN` not defined: both ports remain, tied to 0, and no counter flops are built.

## Structure
- Package `fifo_rd_pkg`:
  - `rd_state_t` enum (`RD_EMPTY`, `RD_ONE`, `RD_TWO`).
  - Constant `RD_BUF_DEPTH`=2.
- Sub-module `fifo_rd_sat_cnt` (parameter `CNT_W`; ports `rclk`, `rrst_n`, `inc`, `count`). Instantiated twice, only under `FIFO_RD_STATS_EN`.

## Test plan
- Reset release with `rempty`=0 and `rdata`=0x10: `rinc`=0 on the first edge, 1 on the second; `m_valid`=1 with `m_data`=0x10 one edge later.
- Stream of 8 words 0x10..0x17 with `m_ready`=1: `m_data` sequence is 0x10..0x17 on consecutive cycles; `pop_count`=8 with stats enabled.
- `m_ready`=0 with FIFO holding 0xA0..0xAF: exactly 2 `rinc` pulses, `m_data`=0xA0 held. Then `m_ready`=1: 0xA0..0xAF emitted in order with no gaps; `stall_count` equals the number of held cycles.
- Buffer in TWO (0x50, 0x51) and `flush`=1 while `rempty`=0: next cycle `m_valid`=0 and no `rinc` during flush. FIFO next delivers 0x52.
- `en`=0 with 1 word buffered: word still delivered, `rinc` stays 0. `rempty`=1 throughout: `rinc` never asserts.
- Assert `rrst_n`=0 while in TWO: `m_valid`, `m_data` and `rinc` go to 0 immediately; with stats enabled, both counters read 0.
